// File: rtl/i2s_tx_master.sv
// Master I2S transmitter: generates aud_bclk/aud_lrc from clk and shifts one stereo word per frame, MSB first.
// Latches aud_data at frame start and pulses tx_done one clk later; define I2S_LEFT_JUSTIFY_EN for left-justified output.
module i2s_tx_master #(
    parameter int WL        = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [2*WL-1:0] aud_data,
    output logic            tx_done,
    output logic            aud_bclk,
    output logic            aud_lrc,
    output logic            aud_dacdat
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_MAX  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_MAX  = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
    localparam logic [BW-1:0] WL_C     = BW'(WL);
`ifdef I2S_LEFT_JUSTIFY_EN
    localparam logic LJ = 1'b1;
`else
    localparam logic LJ = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [2*WL-1:0] shadow_q, shadow_d;
    logic            done_q, done_d;
    logic            bclk_q, bclk_d;
    logic            lrc_q, lrc_d;
    logic            dat_q, dat_d;

    logic            fall, frame_end, upper;
    logic [BW-1:0]   s;
    logic [WL-1:0]   ch, ch_sh;

    always_comb begin
        fall      = (div_q == DIV_MAX);
        frame_end = fall && (bit_q == BIT_MAX);
        state_d   = state_q;
        div_d     = '0;
        bit_d     = '0;
        shadow_d  = shadow_q;
        done_d    = 1'b0;

        // Counters free-run in RUN and DRAIN; they wrap to 0 together at frame end.
        if (state_q != IDLE) begin
            div_d = fall ? '0 : div_q + 1'b1;
            bit_d = !fall ? bit_q : ((bit_q == BIT_MAX) ? '0 : bit_q + 1'b1);
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = RUN;
                    shadow_d = aud_data;
                    done_d   = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    shadow_d = aud_data;
                    done_d   = 1'b1;
                end
                if (!en) state_d = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                    if (frame_end) begin
                        shadow_d = aud_data;
                        done_d   = 1'b1;
                    end
                end else if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from next-state values so every pin is a flop.
        upper = (bit_d >= SLOT);
        s     = upper ? (bit_d - SLOT) : bit_d;
        ch    = upper ? shadow_d[WL-1:0] : shadow_d[2*WL-1:WL];
        ch_sh = LJ ? (ch << s) : (ch << (s - 1'b1));
        bclk_d = 1'b0;
        lrc_d  = 1'b0;
        dat_d  = 1'b0;
        if (state_d != IDLE) begin
            bclk_d = (div_d >= DIV_HALF);
            lrc_d  = upper ^ LJ;
            if (LJ) dat_d = (s < WL_C) ? ch_sh[WL-1] : 1'b0;
            else    dat_d = (s >= BW'(1) && s <= WL_C) ? ch_sh[WL-1] : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            bclk_q   <= 1'b0;
            lrc_q    <= 1'b0;
            dat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
            bclk_q   <= bclk_d;
            lrc_q    <= lrc_d;
            dat_q    <= dat_d;
        end
    end

    assign tx_done    = done_q;
    assign aud_bclk   = bclk_q;
    assign aud_lrc    = lrc_q;
    assign aud_dacdat = dat_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: frame-position reference model checked every clk, plus directed frame/drain/reset steps.
module tb_i2s_tx_master;

    localparam int WL        = 16;
    localparam int SLOT_BITS = 32;
    localparam int BCLK_DIV  = 8;
    localparam int FRAME     = 2 * SLOT_BITS * BCLK_DIV;
`ifdef I2S_LEFT_JUSTIFY_EN
    localparam bit          LJ   = 1'b1;
    localparam logic [31:0] WORD = 32'h8001_7FFE;
`else
    localparam bit          LJ   = 1'b0;
    localparam logic [31:0] WORD = 32'hA5A5_0F0F;
`endif

    logic        clk, rst_n, en;
    logic [31:0] aud_data;
    logic        tx_done, aud_bclk, aud_lrc, aud_dacdat;

    i2s_tx_master #(.WL(WL), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .aud_data(aud_data),
        .tx_done(tx_done), .aud_bclk(aud_bclk), .aud_lrc(aud_lrc), .aud_dacdat(aud_dacdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position inside the current frame plus the word latched for it.
    bit          m_act, m_done, m_en_prev;
    int          m_pos;
    logic [31:0] m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0; m_pos <= 0; m_word <= '0; m_done <= 1'b0; m_en_prev <= 1'b0;
        end else begin
            m_done    <= 1'b0;
            m_en_prev <= en;
            if (!m_act) begin
                if (en) begin
                    m_act <= 1'b1; m_pos <= 0; m_word <= aud_data; m_done <= 1'b1;
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos <= 0;
                // Keeps running if en was seen high at this edge or the one before.
                if (en || m_en_prev) begin
                    m_word <= aud_data; m_done <= 1'b1;
                end else begin
                    m_act <= 1'b0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    function automatic void model_out(input bit act, input int pos, input logic [31:0] w,
                                      output logic b, output logic l, output logic d);
        int bitn, s;
        bit upper;
        logic [WL-1:0] ch;
        b = 1'b0; l = 1'b0; d = 1'b0;
        if (act) begin
            b     = ((pos % BCLK_DIV) >= BCLK_DIV / 2);
            bitn  = pos / BCLK_DIV;
            upper = (bitn >= SLOT_BITS);
            s     = bitn % SLOT_BITS;
            ch    = upper ? w[WL-1:0] : w[2*WL-1:WL];
            l     = upper ^ LJ;
            if (LJ) begin
                if (s < WL) d = ch[WL-1-s];
            end else begin
                if (s >= 1 && s <= WL) d = ch[WL-s];
            end
        end
    endfunction

    int n_assert = 0, n_fail = 0;
    int cyc_n = 0, n_done = 0, last_done_cyc = 0, last_gap = 0;
    bit bclk_prev = 1'b0, cap_on = 1'b0;
    int cap_k = 0, cap_zero_err = 0;
    logic [WL-1:0] cap_l, cap_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic eb, el, ed;
        int s, idx;
        @(negedge clk);
        cyc_n++;
        model_out(m_act, m_pos, m_word, eb, el, ed);
        chk("bclk", aud_bclk, eb);
        chk("lrc", aud_lrc, el);
        chk("dacdat", aud_dacdat, ed);
        chk("tx_done", tx_done, m_done);
        if (tx_done) begin
            n_done++;
            last_gap = cyc_n - last_done_cyc;
            last_done_cyc = cyc_n;
        end
        if (cap_on && aud_bclk && !bclk_prev && cap_k < 64) begin
            s   = cap_k % SLOT_BITS;
            idx = LJ ? (WL - 1 - s) : (WL - s);
            if (idx >= 0 && idx < WL) begin
                if (cap_k < SLOT_BITS) cap_l[idx] = aud_dacdat;
                else                   cap_r[idx] = aud_dacdat;
            end else if (aud_dacdat !== 1'b0) begin
                cap_zero_err++;
            end
            cap_k++;
        end
        bclk_prev = aud_bclk;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc();
            seen = tx_done;
        end
        chk("wait_tx_done", seen, 1);
    endtask

    task automatic wait_pos(input int p, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc();
            seen = m_act && (m_pos == p);
        end
        chk("wait_frame_pos", seen, 1);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; en = 1'b0; aud_data = '0;

        // Reset and long idle.
        run(3);
        chk("rst_outputs", {tx_done, aud_bclk, aud_lrc, aud_dacdat}, 0);
        rst_n = 1'b1;
        run(1000);
        chk("idle_no_done", n_done, 0);

        // Basic frame with bit capture on aud_bclk rising edges.
        aud_data = WORD; cap_on = 1'b1; cap_k = 0; cap_l = '0; cap_r = '0;
        en = 1'b1;
        cyc();
        chk("first_done", tx_done, 1);
        chk("first_lrc", aud_lrc, LJ);
        chk("first_dat", aud_dacdat, LJ ? WORD[31] : 1'b0);
        for (int i = 0; i < 600 && cap_k < 64; i++) cyc();
        cap_on = 1'b0;
        chk("cap_rises", cap_k, 64);
        chk("cap_left", cap_l, WORD[31:16]);
        chk("cap_right", cap_r, WORD[15:0]);
        chk("cap_pad_zero", cap_zero_err, 0);

        // Ten frames, new word supplied on each tx_done.
        for (int f = 0; f < 10; f++) begin
            wait_done(600);
            chk("done_period", last_gap, FRAME);
            aud_data = $urandom;
        end

        // Drop en at bit 10: frame finishes, then idle with no extra tx_done.
        wait_pos(10 * BCLK_DIV, 600);
        en = 1'b0; d0 = n_done;
        run(700);
        chk("drain_no_done", n_done - d0, 0);
        chk("drain_idle", {aud_bclk, aud_lrc, aud_dacdat}, 0);

        // Restart, drop en at bit 10, re-assert at bit 40: next frame latches on time.
        aud_data = $urandom; en = 1'b1;
        wait_done(5);
        wait_pos(10 * BCLK_DIV, 600);
        en = 1'b0;
        wait_pos(40 * BCLK_DIV, 600);
        en = 1'b1; aud_data = $urandom;
        wait_done(600);
        chk("rerun_period", last_gap, FRAME);
        run(FRAME);

        // Asynchronous reset mid-frame while aud_bclk is high.
        wait_pos(20 * BCLK_DIV + BCLK_DIV / 2, 600);
        chk("pre_rst_bclk", aud_bclk, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outputs", {tx_done, aud_bclk, aud_lrc, aud_dacdat}, 0);
        run(3);
        rst_n = 1'b1; aud_data = $urandom;
        cyc();
        chk("post_rst_done", tx_done, 1);
        last_done_cyc = cyc_n;
        wait_done(600);
        chk("post_rst_period", last_gap, FRAME);

        // Random data every clk with occasional en toggles.
        for (int i = 0; i < 4000; i++) begin
            cyc();
            aud_data = $urandom;
            if ($urandom_range(0, 299) == 0) en = ~en;
        end
        en = 1'b0;
        run(2 * FRAME);
        chk("final_idle", {aud_bclk, aud_lrc, aud_dacdat}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
- Master-mode I2S transmitter sitting directly downstream of the music/line-in selection stage.
- Generates aud_bclk and aud_lrc from the system clock and serialises a 32-bit stereo word (left in the upper half, right in the lower) onto aud_dacdat for the WM8978 DAC.
- Pulses tx_done once per frame when it has latched a word. The upstream stage uses tx_done to advance its ROM read address, so fresh data is ready before the next frame.

Parameters:
- WL, 16: bits per channel sample. Must satisfy 1 ≤ WL ≤ SLOT_BITS-1.
- SLOT_BITS, 32: aud_bclk periods per channel slot. A frame is 2*SLOT_BITS aud_bclk periods.
- BCLK_DIV, 8: clk cycles per aud_bclk period. Must be even and ≥ 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous reset, active-low.
- en, input, 1: run request.
- aud_data, input, 2*WL: stereo word. [2WL-1:WL] is left, [WL-1:0] is right.
- tx_done, output, 1: one-clk pulse per latched frame.
- aud_bclk, output, 1: I2S bit clock.
- aud_lrc, output, 1: word select. 0 = left, 1 = right.
- aud_dacdat, output, 1: serial data, MSB first.

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous and active-low (clk, rst_n).
  - Reset forces state=IDLE, all counters=0, shadow=0, and all outputs=0. This applies at any time, including mid-frame.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - aud_bclk=0, aud_lrc=0, aud_dacdat=0, tx_done=0.
  - div_cnt and bit_cnt are held at 0.
  - When en=1 at an edge, go to RUN. On that same edge, latch aud_data into the shadow register.
- RUN and DRAIN counters:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - aud_bclk = (div_cnt ≥ BCLK_DIV/2), registered.
  - A "fall event" is the cycle div_cnt wraps to 0.
  - bit_cnt counts 0..2*SLOT_BITS-1 and advances only on fall events, wrapping to 0.
- Outputs in RUN and DRAIN:
  - aud_lrc = (bit_cnt ≥ SLOT_BITS). It changes only on fall events.
  - Let s = bit_cnt mod SLOT_BITS and ch = the shadow half selected by aud_lrc.
  - aud_dacdat = ch[WL-s] for 1 ≤ s ≤ WL, otherwise 0. This is the standard one-bit I2S delay.
  - aud_dacdat changes only on fall events, so it is stable at every aud_bclk rising edge.
- Frame latch (RUN only):
  - On the fall event where bit_cnt wraps from 2*SLOT_BITS-1 to 0, latch aud_data into the shadow register.
  - aud_data is sampled only at latch edges; changes between latches are ignored.
- tx_done:
  - Asserted for exactly one clk, in the cycle after each latch, including the initial latch on IDLE→RUN.
  - Period in steady RUN = 2*SLOT_BITS*BCLK_DIV clk cycles.
- en deasserted in RUN:
  - Go to DRAIN. The current frame completes unchanged.
- DRAIN:
  - On the frame-end fall event: if en=0, go to IDLE with no latch and no tx_done. The outputs return to 0 on that edge.
  - If en=1 at any point in DRAIN, go back to RUN without disturbing the counters. The next frame-end latches normally.
- Simultaneous events: a frame-end fall event in RUN with en=0 in the same cycle latches (state is still RUN), then goes to DRAIN for the new frame.
- All outputs are driven directly from flops. No combinational path from aud_data to any output.

Optional Feature:
- Macro: I2S_LEFT_JUSTIFY_EN.
- When defined, the block runs in left-justified format:
  - No one-bit delay: aud_dacdat = ch[WL-1-s] for 0 ≤ s ≤ WL-1, otherwise 0.
  - aud_lrc polarity is inverted: 1 = left.
  - The WL limit relaxes to ≤ SLOT_BITS.
- When undefined: standard I2S exactly as in Behaviour.

Test Plan (defaults WL=16, SLOT_BITS=32, BCLK_DIV=8, so one frame = 512 clk):
- Reset/idle: rst_n=0, then 1, en=0 for 1000 clk -> all outputs 0, no tx_done.
- Basic frame: en=1, aud_data=32'hA5A5_0F0F held -> tx_done 1 clk after start.
  - aud_lrc=0 for 256 clk, then 1 for 256 clk.
  - Bits sampled on aud_bclk rising edges at s=1..16 give 16'hA5A5 in the left slot and 16'h0F0F in the right slot.
  - Bits at s=0 and s=17..31 are 0.
- Periodic handshake: run 10 frames, changing aud_data only on tx_done -> tx_done interval is exactly 512 clk, and each frame serialises the word supplied before its latch.
- Drain and re-run:
  - Drop en at bit_cnt=10 -> the frame completes, the block goes idle at the frame end, with no extra tx_done.
  - Repeat, re-asserting en at bit_cnt=40 -> the next frame latches normally with no gap.
- Async reset mid-frame: pulse rst_n low at bit_cnt=20 -> outputs 0 immediately.
  - After release with en=1, the first tx_done comes 1 clk after the first edge, and the frame timing restarts from 0.
- Optional macro defined: aud_data=32'h8001_7FFE -> the left MSB 1 appears at s=0 with aud_lrc=1, and the right 16'h7FFE appears at s=0..15 with aud_lrc=0.
